// File: rtl/rr_arbiter8.sv
// rr_arbiter8 - eight-requester round-robin arbiter with grant hold.
//
// The winner is the first requester found scanning from ptr upward, wrapping
// 7 -> 0. A grant is held until the owner asserts done, drops its request,
// or has held the resource for MAX_HOLD BUSY cycles. Every release rotates
// ptr to the slot after the released owner and forces one IDLE cycle.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   req        in   8  level-sensitive request vector, bit k = requester k
//   done       in   1  owner releases the resource (sampled only in BUSY)
//   gnt        out  8  registered one-hot grant, zero when nothing granted
//   gnt_idx    out  3  binary index of the gnt bit, zero when no grant
//   gnt_valid  out  1  high while a grant is held
//   timeout    out  1  one-cycle pulse when the hold limit alone forced release
//
// MAX_HOLD (0..255): hold limit in BUSY cycles; 0 disables the limit.

module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_ptr;
  logic [2:0] w_ptr_nxt;
  logic [7:0] r_hold_cnt;
  logic [7:0] w_hold_cnt_nxt;
  logic [7:0] r_gnt;
  logic [7:0] w_gnt_nxt;
  logic [2:0] r_gnt_idx;
  logic [2:0] w_gnt_idx_nxt;
  logic       r_gnt_valid;
  logic       w_gnt_valid_nxt;
  logic       r_timeout;
  logic       w_timeout_nxt;

  // Rotate the request vector so that position ptr lands at bit 0; the
  // lowest set bit of the rotated vector is then the offset of the winner.
  logic [15:0] w_req_dbl;
  logic [7:0]  w_req_rot;
  logic [2:0]  w_ofs;
  logic        w_found;
  logic [2:0]  w_winner;

  assign w_req_dbl = {req, req} >> r_ptr;
  assign w_req_rot = w_req_dbl[7:0];

  always_comb begin
    w_ofs   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!w_found && w_req_rot[i]) begin
        w_ofs   = 3'(i);
        w_found = 1'b1;
      end
    end
  end

  assign w_winner = r_ptr + w_ofs;

  logic w_rel_done;
  logic w_rel_drop;
  logic w_rel_limit;

  assign w_rel_done  = done;
  assign w_rel_drop  = ~req[r_gnt_idx];
  assign w_rel_limit = (MAX_HOLD != 0) && (r_hold_cnt == 8'(MAX_HOLD));

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_gnt_nxt       = r_gnt;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_gnt_valid_nxt = r_gnt_valid;
    w_timeout_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_gnt_nxt       = 8'b1 << w_winner;
          w_gnt_idx_nxt   = w_winner;
          w_gnt_valid_nxt = 1'b1;
          w_hold_cnt_nxt  = 8'd1;
          w_state_nxt     = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (w_rel_done || w_rel_drop || w_rel_limit) begin
          w_gnt_nxt       = '0;
          w_gnt_idx_nxt   = '0;
          w_gnt_valid_nxt = 1'b0;
          w_hold_cnt_nxt  = '0;
          w_ptr_nxt       = r_gnt_idx + 3'd1;
          w_state_nxt     = ST_IDLE;
          // Only flag a timeout when the limit was the sole reason to release.
          w_timeout_nxt   = w_rel_limit && !w_rel_done && !w_rel_drop;
        end else if (r_hold_cnt != '1) begin
          w_hold_cnt_nxt  = r_hold_cnt + 8'd1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8: two instances (hold limit 16 and limit disabled)
// share the same stimulus. A behavioural model predicts each cycle's outputs
// into a queue; a monitor pops and compares after every rising edge.

module tb_rr_arbiter8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req   = '0;
  logic       done  = 1'b0;

  logic [7:0] gnt_a, gnt_b;
  logic [2:0] idx_a, idx_b;
  logic       val_a, val_b;
  logic       to_a, to_b;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a), .timeout(to_a)
  );

  rr_arbiter8 #(.MAX_HOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b), .timeout(to_b)
  );

  // Model state: owner = -1 when nothing is granted.
  typedef struct {
    int owner;
    int held;
    int ptr;
    bit to;
  } mdl_t;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] i;
    logic       v;
    logic       t;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } rec_t;

  rec_t q[$];
  int   glog[$];
  mdl_t ma = '{-1, 0, 0, 1'b0};
  mdl_t mb = '{-1, 0, 0, 1'b0};
  int   checks = 0;
  int   errors = 0;

  function automatic mdl_t step(mdl_t s, logic [7:0] r, logic d, logic rst, int mh);
    mdl_t n;
    bit   found;
    bit   by_owner;
    n = s;
    n.to = 1'b0;
    found = 1'b0;
    if (!rst) begin
      n.owner = -1;
      n.held  = 0;
      n.ptr   = 0;
    end else if (s.owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        if (!found && r[(s.ptr + k) % 8]) begin
          found   = 1'b1;
          n.owner = (s.ptr + k) % 8;
          n.held  = 1;
        end
      end
    end else begin
      by_owner = d || !r[s.owner];
      if (by_owner || (mh != 0 && s.held == mh)) begin
        n.to    = !by_owner;
        n.ptr   = (s.owner + 1) % 8;
        n.owner = -1;
        n.held  = 0;
      end else begin
        n.held = (s.held < 255) ? s.held + 1 : 255;
      end
    end
    return n;
  endfunction

  function automatic exp_t view(mdl_t s);
    exp_t e;
    e.v = (s.owner >= 0);
    e.g = e.v ? 8'(1 << s.owner) : 8'h00;
    e.i = e.v ? 3'(s.owner) : 3'd0;
    e.t = s.to;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle: drive at the falling edge, predict the post-edge outputs.
  task automatic cyc(input logic [7:0] r, input logic d, input logic rst);
    @(negedge clk);
    req   = r;
    done  = d;
    rst_n = rst;
    ma = step(ma, r, d, rst, 16);
    mb = step(mb, r, d, rst, 0);
    q.push_back('{view(ma), view(mb)});
    if (!rst) begin
      #1;
      chk("async_rst_a", {gnt_a, idx_a, val_a, to_a}, 32'd0);
      chk("async_rst_b", {gnt_b, idx_b, val_b, to_b}, 32'd0);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    rec_t e;
    logic pv;
    pv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt_a",     gnt_a, e.a.g);
        chk("gnt_idx_a", idx_a, e.a.i);
        chk("valid_a",   val_a, e.a.v);
        chk("timeout_a", to_a,  e.a.t);
        chk("gnt_b",     gnt_b, e.b.g);
        chk("gnt_idx_b", idx_b, e.b.i);
        chk("valid_b",   val_b, e.b.v);
        chk("timeout_b", to_b,  e.b.t);
      end
      if (val_a && !pv) glog.push_back(int'(idx_a));
      pv = val_a;
    end
  end

  int seq_rot[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

  initial begin
    logic [7:0] r;
    int         budget;

    // Reset.
    repeat (3) cyc(8'h00, 1'b0, 1'b0);
    repeat (2) cyc(8'h00, 1'b0, 1'b1);

    // Single request, then release via done (ptr -> 6).
    repeat (3) cyc(8'h20, 1'b0, 1'b1);
    cyc(8'h20, 1'b1, 1'b1);
    repeat (3) cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h60, 1'b0, 1'b1);            // ptr=6 must pick 6 over 5
    cyc(8'h60, 1'b1, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);

    // Full rotation from ptr=0, done on the second BUSY cycle of each grant.
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b1);
    glog.delete();
    repeat (40) cyc(8'hFF, (ma.owner >= 0 && ma.held == 2), 1'b1);
    chk("rot_count", (glog.size() >= 9), 1);
    if (glog.size() >= 9)
      for (int k = 0; k < 9; k++) chk("rot_seq", glog[k], seq_rot[k]);

    // Timeout: requesters 0 and 1, no done.
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b1);
    glog.delete();
    repeat (40) cyc(8'h03, 1'b0, 1'b1);
    chk("to_count", (glog.size() >= 2), 1);
    if (glog.size() >= 2) begin
      chk("to_first", glog[0], 0);
      chk("to_second", glog[1], 1);
    end

    // Owner 3 drops its request mid-grant.
    repeat (2) cyc(8'h00, 1'b0, 1'b1);
    repeat (5) cyc(8'h08, 1'b0, 1'b1);
    repeat (3) cyc(8'h00, 1'b0, 1'b1);

    // done coincides with the hold limit.
    repeat (25) cyc(8'h01, (ma.owner >= 0 && ma.held == 16), 1'b1);
    repeat (2) cyc(8'h00, 1'b0, 1'b1);

    // Wrap: get ptr to 7, then req=81 grants 7 then 0.
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b1);
    repeat (2) cyc(8'h40, 1'b0, 1'b1);
    cyc(8'h40, 1'b1, 1'b1);
    glog.delete();
    repeat (14) cyc(8'h81, (ma.owner >= 0 && ma.held == 3), 1'b1);
    chk("wrap_count", (glog.size() >= 2), 1);
    if (glog.size() >= 2) begin
      chk("wrap_first", glog[0], 7);
      chk("wrap_second", glog[1], 0);
    end

    // Asynchronous reset mid-grant.
    budget = 0;
    while (ma.owner < 0 && budget < 10) begin
      cyc(8'h81, 1'b0, 1'b1);
      budget++;
    end
    chk("grant_before_reset", (ma.owner >= 0), 1);
    cyc(8'h81, 1'b0, 1'b1);
    cyc(8'h81, 1'b0, 1'b0);
    glog.delete();
    repeat (4) cyc(8'h81, 1'b0, 1'b1);
    chk("post_rst_count", (glog.size() >= 1), 1);
    if (glog.size() >= 1) chk("post_rst_first", glog[0], 0);

    // Long hold: limit-disabled instance keeps the grant for 300 cycles.
    cyc(8'h81, 1'b1, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);
    repeat (300) cyc(8'h04, 1'b0, 1'b1);
    cyc(8'h04, 1'b1, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 1) == 0) r = r & 8'($urandom);
      if ($urandom_range(0, 5) == 0) r = 8'h00;
      cyc(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) != 0));
    end

    repeat (3) cyc(8'h00, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
